// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - state_e          : converter FSM state encoding
//   - DIGIT_ADJ_THRESH : digit value from which the add-3 correction applies
//   - ADJ              : the correction added to such a digit
//   - min_digits()     : decimal digits needed to show any width-bit unsigned
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] DIGIT_ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ              = 4'd3;

  // Number of decimal digits of (2^width - 1); fewer digits than this means
  // the converter can overflow.
  function automatic int min_digits(input int width);
    longint unsigned max_val;
    longint unsigned pow10;
    int              d;
    max_val = (64'd1 << width) - 64'd1;
    pow10   = 64'd1;
    d       = 0;
    for (int i = 0; i < 11; i++) begin
      if (pow10 <= max_val) begin
        pow10 = pow10 * 64'd10;
        d     = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble cell: a digit of 5 or more gets +3 so that the
// following left shift carries into the next decimal digit.
// Ports:
//   digit_i [3:0] : BCD digit before the shift
//   digit_o [3:0] : corrected digit, ready to be shifted
// -----------------------------------------------------------------------------
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Add-3 correction for digits at or above the threshold.
  always_comb begin
    if (digit_i >= DIGIT_ADJ_THRESH) begin
      digit_o = digit_i + ADJ;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// -----------------------------------------------------------------------------
// bcd_seq_converter
// Multi-cycle binary-to-BCD converter (shift-and-add-3), one input bit per
// clock, with optional sign-magnitude handling and overflow detection.
// Parameters:
//   BIN_W  : binary input width (2..32)
//   DIGITS : number of BCD digits produced (1..10)
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : conversion request, accepted only when idle
//   signed_en : treat bin_in as two's complement (sampled with start)
//   bin_in    : binary value (sampled with start)
//   busy      : conversion in progress
//   done      : one-cycle pulse, results valid from this cycle on
//   bcd_out   : result digits, digit k in bits [4k+3:4k], k=0 is ones
//   negative  : result sign
//   overflow  : magnitude did not fit; bcd_out holds the low digits
// -----------------------------------------------------------------------------
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                signed_en,
  input  logic [BIN_W-1:0]    bin_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                negative,
  output logic                overflow
);

  localparam int                ACC_W        = 4 * DIGITS;
  localparam int                CNT_W        = $clog2(BIN_W);
  localparam logic [CNT_W-1:0]  CNT_LOAD     = CNT_W'(BIN_W - 1);
  localparam logic              OVF_POSSIBLE = (DIGITS < min_digits(BIN_W));

  if ((BIN_W < 2) || (BIN_W > 32)) begin : g_bad_bin_w
    $error("bcd_seq_converter: BIN_W must be within 2..32");
  end
  if ((DIGITS < 1) || (DIGITS > 10)) begin : g_bad_digits
    $error("bcd_seq_converter: DIGITS must be within 1..10");
  end

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIN_W-1:0]   mag_q;
  logic [ACC_W-1:0]   acc_q;
  logic               ovf_q;
  logic               neg_q;
  logic               busy_q;
  logic               done_q;
  logic [ACC_W-1:0]   bcd_q;
  logic               negative_q;
  logic               overflow_q;

  logic               neg_in_s;
  logic [BIN_W-1:0]   mag_in_s;
  logic [ACC_W-1:0]   adj_s;

  assign neg_in_s = signed_en & bin_in[BIN_W-1];

  // Magnitude of the incoming value; the most-negative input maps to
  // 2^(BIN_W-1), which still fits as an unsigned BIN_W-bit number.
  always_comb begin
    if (neg_in_s) begin
      mag_in_s = (~bin_in) + BIN_W'(1);
    end else begin
      mag_in_s = bin_in;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[4*k +: 4]),
      .digit_o (adj_s[4*k +: 4])
    );
  end

  // Converter FSM: capture, shift-and-add-3 loop, result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      neg_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            // The MSB enters the cleared accumulator right away (adjusting an
            // all-zero accumulator is a no-op), so SHIFT needs BIN_W-1 cycles
            // and the DONE cycle still falls within the busy window.
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_LOAD;
            acc_q   <= ACC_W'(mag_in_s[BIN_W-1]);
            mag_q   <= {mag_in_s[BIN_W-2:0], 1'b0};
            ovf_q   <= 1'b0;
            neg_q   <= neg_in_s;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          acc_q <= {adj_s[ACC_W-2:0], mag_q[BIN_W-1]};
          mag_q <= {mag_q[BIN_W-2:0], 1'b0};
          ovf_q <= ovf_q | (OVF_POSSIBLE & adj_s[ACC_W-1]);
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          bcd_q      <= acc_q;
          negative_q <= neg_q;
          overflow_q <= ovf_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign negative = negative_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// -----------------------------------------------------------------------------
// tb_bcd_seq_converter
// Drives a 5-digit and a 4-digit converter (BIN_W=16) from the same stimulus
// and compares both against an arithmetic decimal reference.
// -----------------------------------------------------------------------------
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic        signed_en = 1'b0;
  logic [15:0] bin_in = 16'd0;

  logic        busy5, done5, neg5, ovf5;
  logic [19:0] bcd5;
  logic        busy4, done4, neg4, ovf4;
  logic [15:0] bcd4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bcd_seq_converter #(.BIN_W(16), .DIGITS(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_en(signed_en),
    .bin_in(bin_in), .busy(busy5), .done(done5), .bcd_out(bcd5),
    .negative(neg5), .overflow(ovf5)
  );

  bcd_seq_converter #(.BIN_W(16), .DIGITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_en(signed_en),
    .bin_in(bin_in), .busy(busy4), .done(done4), .bcd_out(bcd4),
    .negative(neg4), .overflow(ovf4)
  );

  typedef struct {
    logic        se;
    logic [15:0] v;
    logic [19:0] bcd5;
    logic        neg;
    logic        ovf5;
    logic [15:0] bcd4;
    logic        ovf4;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Decimal reference: magnitude by plain arithmetic, digits by repeated /10.
  function automatic void model(input logic se, input logic [15:0] v, input int digits,
                                output logic [31:0] bcd, output logic neg, output logic ovf);
    int unsigned mag;
    int unsigned m;
    int unsigned lim;
    neg = se && v[15];
    mag = neg ? (32'd65536 - 32'(v)) : 32'(v);
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    ovf = (mag >= lim);
    bcd = 32'd0;
    m = mag;
    for (int i = 0; i < digits; i++) begin
      bcd = bcd | ((m % 10) << (4 * i));
      m = m / 10;
    end
  endfunction

  // Issue start now (caller sits on a negedge); optionally pulse a stray
  // start at cycle inj_cyc after acceptance. Returns in the done cycle.
  task automatic run_conv(input logic se, input logic [15:0] v,
                          input logic [19:0] e5b, input logic en, input logic e5o,
                          input logic [15:0] e4b, input logic e4o,
                          input int inj_cyc, input logic [15:0] inj_val);
    int k;
    bit busy_ok;
    start = 1'b1;
    signed_en = se;
    bin_in = v;
    @(negedge clk);
    k = 1;
    busy_ok = 1'b1;
    signed_en = 1'($urandom);
    while (done5 !== 1'b1 && k < 40) begin
      if (busy5 !== 1'b1) busy_ok = 1'b0;
      start = (k == inj_cyc);
      bin_in = inj_val;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("latency", 32'(k), 32'd17);
    check("busy_window", 32'(busy_ok), 32'd1);
    check("busy_low_at_done", 32'(busy5), 32'd0);
    check("done4", 32'(done4), 32'd1);
    check("bcd5", 32'(bcd5), 32'(e5b));
    check("neg5", 32'(neg5), 32'(en));
    check("ovf5", 32'(ovf5), 32'(e5o));
    check("bcd4", 32'(bcd4), 32'(e4b));
    check("neg4", 32'(neg4), 32'(en));
    check("ovf4", 32'(ovf4), 32'(e4o));
  endtask

  task automatic quiet_window(input string name, input int cycles);
    int dones;
    int busies;
    dones = 0;
    busies = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done5 === 1'b1) dones++;
      if (busy5 === 1'b1) busies++;
    end
    check({name, "_no_done"}, 32'(dones), 32'd0);
    check({name, "_no_busy"}, 32'(busies), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m5b, m4b;
    logic        mn, m5o, m4o, dn;
    logic [15:0] rv;
    logic        rs;

    tbl[0] = '{1'b0, 16'hFFFF, 20'h65535, 1'b0, 1'b0, 16'h5535, 1'b1};
    tbl[1] = '{1'b0, 16'd9999, 20'h09999, 1'b0, 1'b0, 16'h9999, 1'b0};
    tbl[2] = '{1'b0, 16'd0,    20'h00000, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[3] = '{1'b1, 16'hFFFF, 20'h00001, 1'b1, 1'b0, 16'h0001, 1'b0};
    tbl[4] = '{1'b1, 16'h8000, 20'h32768, 1'b1, 1'b0, 16'h2768, 1'b1};
    tbl[5] = '{1'b0, 16'd12345,20'h12345, 1'b0, 1'b0, 16'h2345, 1'b1};
    tbl[6] = '{1'b0, 16'd42,   20'h00042, 1'b0, 1'b0, 16'h0042, 1'b0};
    tbl[7] = '{1'b1, 16'd0,    20'h00000, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[8] = '{1'b1, 16'h7FFF, 20'h32767, 1'b0, 1'b0, 16'h2767, 1'b1};
    tbl[9] = '{1'b0, 16'd10000,20'h10000, 1'b0, 1'b0, 16'h0000, 1'b1};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy5), 32'd0);
    check("rst_done", 32'(done5), 32'd0);
    check("rst_bcd", 32'(bcd5), 32'd0);
    check("rst_neg", 32'(neg5), 32'd0);
    check("rst_ovf", 32'(ovf5), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table applied back-to-back: each start is raised in the done cycle.
    for (int i = 0; i < 10; i++) begin
      run_conv(tbl[i].se, tbl[i].v, tbl[i].bcd5, tbl[i].neg, tbl[i].ovf5,
               tbl[i].bcd4, tbl[i].ovf4, 0, 16'd0);
    end
    @(negedge clk);
    check("done_pulse_width", 32'(done5), 32'd0);
    check("hold_bcd5", 32'(bcd5), 32'h10000);

    // Stray start mid-conversion, then a stray start during the DONE cycle.
    @(negedge clk);
    run_conv(1'b0, 16'd1234, 20'h01234, 1'b0, 1'b0, 16'h1234, 1'b0, 5, 16'd777);
    quiet_window("inj5", 20);
    run_conv(1'b1, 16'hFF85, 20'h00123, 1'b1, 1'b0, 16'h0123, 1'b0, 16, 16'd4321);
    quiet_window("inj16", 20);

    // Reset in the middle of a conversion, with non-zero held outputs.
    run_conv(1'b1, 16'h8000, 20'h32768, 1'b1, 1'b0, 16'h2768, 1'b1, 0, 16'd0);
    @(negedge clk);
    start = 1'b1; signed_en = 1'b0; bin_in = 16'd4321;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy5), 32'd0);
    check("arst_bcd", 32'(bcd5), 32'd0);
    check("arst_neg", 32'(neg5), 32'd0);
    check("arst_ovf4", 32'(ovf4), 32'd0);
    check("arst_done", 32'(done5), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet_window("post_rst", 25);
    run_conv(1'b0, 16'd255, 20'h00255, 1'b0, 1'b0, 16'h0255, 1'b0, 0, 16'd0);

    // Randomized conversions against the decimal reference.
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 7))
        0: rv = 16'h8000;
        1: rv = 16'hFFFF;
        2: rv = 16'd9999;
        3: rv = 16'd10000;
        default: rv = 16'($urandom);
      endcase
      rs = 1'($urandom);
      model(rs, rv, 5, m5b, mn, m5o);
      model(rs, rv, 4, m4b, dn, m4o);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check("rnd_done_low", 32'(done5), 32'd0);
      end
      run_conv(rs, rv, m5b[19:0], mn, m5o, m4b[15:0], m4o, 0, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
- Multi-cycle, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Processes one input bit per clock and uses a start/busy/done handshake.
- Supports any input width and digit count, an optional signed (sign-magnitude) mode, and overflow detection.
- Feeds the board display path (7-segment driver) and the debug/register readout of the pipelined RISC-V core.

Parameters:
- BIN_W, 16, width of binary input (2..32).
- DIGITS, 5, number of BCD digits produced (1..10).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion; sampled only in IDLE.
- signed_en  input  1  treat bin_in as two's complement; sampled with start.
- bin_in  input  BIN_W  binary value; sampled with start.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse when results are valid.
- bcd_out  output  4*DIGITS  result; digit k occupies bits [4k+3:4k], k=0 is ones.
- negative  output  1  result sign (1 only when signed_en and input < 0).
- overflow  output  1  magnitude exceeded 10^DIGITS-1; bcd_out holds the truncated low digits.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; shift, counter and digit registers clear.
  - busy=0, done=0, bcd_out=0, negative=0, overflow=0.
  - Reset asserted mid-conversion aborts the conversion immediately; no done pulse follows.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 captures the magnitude and sign, clears the digit accumulator and the overflow flag, loads bit counter = BIN_W-1, and moves to SHIFT.
  - Magnitude: if signed_en=1 and bin_in[BIN_W-1]=1, use the two's complement negation, held in BIN_W bits unsigned. The most-negative value is therefore 2^(BIN_W-1) exactly. Otherwise use bin_in as-is.
- SHIFT, one input bit per cycle, MSB first:
  - Every digit >=5 gets +3 first.
  - Then the whole accumulator shifts left by one, with the next magnitude bit entering bit 0.
  - A 1 shifted out of the top digit's bit 3 sets the sticky overflow flag.
  - After BIN_W shift cycles (counter reaches 0), go to DONE.
- DONE (one cycle): register bcd_out, negative and overflow, pulse done=1, return to IDLE.
- Latency: start seen high at edge N; busy=1 for cycles N+1..N+BIN_W; done=1 in cycle N+BIN_W+1; outputs valid from then on.
- Outputs hold their last result until the next done; there is no change between conversions.
- A new start may be issued in the cycle after done.
- start while busy or in DONE is ignored and not queued.
- bin_in and signed_en are don't-care except at start acceptance.
- A zero input gives bcd_out=0 and negative=0, including signed zero.
- DIGITS >= ceil(BIN_W*log10(2)) means overflow can never assert.

Decomposition:
- Shared package bcd_pkg holds:
  - FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - constant DIGIT_ADJ_THRESH=4'd5 and ADJ=4'd3;
  - function min_digits(width) for parameter checks.
- One natural sub-module, bcd_digit_adj: a combinational 4-bit add-3-if->=5 cell, instantiated DIGITS times via generate.
- The FSM, counter and shift register stay in the top module.

Test Plan:
- BIN_W=16, DIGITS=5, signed_en=0, bin_in=16'hFFFF, start pulse -> done exactly 17 cycles after the start edge; bcd_out=20'h65535, overflow=0, negative=0.
- bin_in=16'd9999 then 16'd0 back-to-back (second start in the cycle after done) -> 20'h09999 then 20'h00000; busy is low for exactly one cycle between conversions.
- signed_en=1, bin_in=16'hFFFF -> bcd_out=20'h00001, negative=1. Then bin_in=16'h8000 -> bcd_out=20'h32768, negative=1.
- DIGITS=4, bin_in=16'd12345 -> overflow=1, bcd_out=16'h2345. Next conversion of 16'd42 -> overflow=0, bcd_out=16'h0042.
- start pulsed again at cycle 5 of an active conversion with a different bin_in -> ignored; exactly one done, carrying the first value's result.
- rst_n driven low at cycle 8 of a conversion -> all outputs 0 asynchronously; no done pulse; after release, a fresh start of 16'd255 gives 20'h00255.
